// File: rtl/rgb_hue_sequencer_if.sv
// Interface: rgb_hue_sequencer_if
//
// Groups the control inputs and the LED-side outputs of the hue sequencer.
//   master : drives en/restart, observes phase, duties, PWM pins and pulses
//   slave  : the sequencer itself
//
// Signals
//   en          1   advance the fade (PWM runs regardless)
//   restart     1   synchronous one-cycle return to the reset state
//   phase       3   current hue phase 0..5
//   duty_r/g/b  DW  per-channel duty, 0..PWM_INTERVAL
//   pwm_r/g/b   1   registered PWM outputs
//   step_tick   1   pulse on each duty update
//   phase_done  1   pulse on each phase advance
interface rgb_hue_sequencer_if #(
    parameter int DW = 11
);
    logic          en;
    logic          restart;
    logic [2:0]    phase;
    logic [DW-1:0] duty_r;
    logic [DW-1:0] duty_g;
    logic [DW-1:0] duty_b;
    logic          pwm_r;
    logic          pwm_g;
    logic          pwm_b;
    logic          step_tick;
    logic          phase_done;

    modport master (
        output en, restart,
        input  phase, duty_r, duty_g, duty_b,
        input  pwm_r, pwm_g, pwm_b, step_tick, phase_done
    );

    modport slave (
        input  en, restart,
        output phase, duty_r, duty_g, duty_b,
        output pwm_r, pwm_g, pwm_b, step_tick, phase_done
    );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// Module: rgb_hue_sequencer
//
// Walks an RGB LED around the hue wheel in six fade phases. In each phase one
// channel ramps up or down by DUTY_STEP per duty update while the other two
// hold at full or zero; the last update of a phase snaps the ramping channel
// to its end value so truncation error never accumulates. A shared PWM
// counter turns the three duties into registered PWM outputs.
//
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of rgb_hue_sequencer_if (en, restart, phase,
//         duty_r/g/b, pwm_r/g/b, step_tick, phase_done)
//
// The interface DW parameter must equal $clog2(PWM_INTERVAL+1), and
// PWM_INTERVAL/STEPS_PER_PHASE must be at least 1.
module rgb_hue_sequencer #(
    parameter int CLK_PER_STEP    = 12000,
    parameter int PWM_INTERVAL    = 1200,
    parameter int STEPS_PER_PHASE = 167
) (
    input logic                clk,
    input logic                rst,
    rgb_hue_sequencer_if.slave bus
);
    localparam int DUTY_STEP = PWM_INTERVAL / STEPS_PER_PHASE;
    localparam int DW = $clog2(PWM_INTERVAL + 1);
    localparam int PW = (CLK_PER_STEP > 1) ? $clog2(CLK_PER_STEP) : 1;
    localparam int SW = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;

    localparam logic [DW-1:0] FULL       = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] STEP       = DW'(DUTY_STEP);
    localparam logic [DW-1:0] PWM_LAST   = DW'(PWM_INTERVAL - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_STEP - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_PHASE - 1);
    localparam logic [2:0]    PHASE_LAST = 3'd5;

    typedef enum logic [1:0] {
        MODE_HOLD_HI,
        MODE_HOLD_LO,
        MODE_RISE,
        MODE_FALL
    } chan_mode_e;

    logic [PW-1:0] presc_q,      presc_d;
    logic [SW-1:0] step_cnt_q,   step_cnt_d;
    logic [2:0]    phase_q,      phase_d;
    logic [DW-1:0] duty_r_q,     duty_r_d;
    logic [DW-1:0] duty_g_q,     duty_g_d;
    logic [DW-1:0] duty_b_q,     duty_b_d;
    logic [DW-1:0] pwm_cnt_q,    pwm_cnt_d;
    logic          pwm_r_q,      pwm_r_d;
    logic          pwm_g_q,      pwm_g_d;
    logic          pwm_b_q,      pwm_b_d;
    logic          step_tick_q,  step_tick_d;
    logic          phase_done_q, phase_done_d;

    chan_mode_e mode_r, mode_g, mode_b;
    logic       update;
    logic       last_step;

    // One duty update for a channel. Hold modes leave the value alone; the
    // ramps saturate, and on the last step of a phase they snap to the end.
    function automatic logic [DW-1:0] next_duty(
        input chan_mode_e    mode,
        input logic [DW-1:0] duty,
        input logic          last
    );
        logic [DW-1:0] res;
        res = duty;
        case (mode)
            MODE_RISE: res = (last || duty >= FULL - STEP) ? FULL : duty + STEP;
            MODE_FALL: res = (last || duty <= STEP) ? '0 : duty - STEP;
            default:   res = duty;
        endcase
        return res;
    endfunction

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            step_cnt_q   <= '0;
            phase_q      <= '0;
            duty_r_q     <= FULL;
            duty_g_q     <= '0;
            duty_b_q     <= '0;
            pwm_cnt_q    <= '0;
            pwm_r_q      <= 1'b0;
            pwm_g_q      <= 1'b0;
            pwm_b_q      <= 1'b0;
            step_tick_q  <= 1'b0;
            phase_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            step_cnt_q   <= step_cnt_d;
            phase_q      <= phase_d;
            duty_r_q     <= duty_r_d;
            duty_g_q     <= duty_g_d;
            duty_b_q     <= duty_b_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_r_q      <= pwm_r_d;
            pwm_g_q      <= pwm_g_d;
            pwm_b_q      <= pwm_b_d;
            step_tick_q  <= step_tick_d;
            phase_done_q <= phase_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        presc_d      = presc_q;
        step_cnt_d   = step_cnt_q;
        phase_d      = phase_q;
        duty_r_d     = duty_r_q;
        duty_g_d     = duty_g_q;
        duty_b_d     = duty_b_q;
        step_tick_d  = 1'b0;
        phase_done_d = 1'b0;

        update    = bus.en && (presc_q == PRESC_LAST);
        last_step = (step_cnt_q == STEP_LAST);

        // The PWM path ignores en so the LED keeps its colour while frozen.
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        pwm_r_d   = (pwm_cnt_q < duty_r_q);
        pwm_g_d   = (pwm_cnt_q < duty_g_q);
        pwm_b_d   = (pwm_cnt_q < duty_b_q);

        if (update) begin
            presc_d     = '0;
            step_tick_d = 1'b1;
            duty_r_d    = next_duty(mode_r, duty_r_q, last_step);
            duty_g_d    = next_duty(mode_g, duty_g_q, last_step);
            duty_b_d    = next_duty(mode_b, duty_b_q, last_step);
            if (last_step) begin
                step_cnt_d   = '0;
                phase_d      = (phase_q == PHASE_LAST) ? 3'd0 : phase_q + 3'd1;
                phase_done_d = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end else if (bus.en) begin
            presc_d = presc_q + 1'b1;
        end

        // restart overrides everything above, including a coincident update.
        if (bus.restart) begin
            presc_d      = '0;
            step_cnt_d   = '0;
            phase_d      = '0;
            duty_r_d     = FULL;
            duty_g_d     = '0;
            duty_b_d     = '0;
            pwm_cnt_d    = '0;
            pwm_r_d      = 1'b0;
            pwm_g_d      = 1'b0;
            pwm_b_d      = 1'b0;
            step_tick_d  = 1'b0;
            phase_done_d = 1'b0;
        end
    end

    // Output decode: channel behaviour for the current phase.
    always_comb begin
        mode_r = MODE_HOLD_HI;
        mode_g = MODE_HOLD_LO;
        mode_b = MODE_HOLD_LO;
        case (phase_q)
            3'd0:    begin mode_r = MODE_HOLD_HI; mode_g = MODE_RISE;    mode_b = MODE_HOLD_LO; end
            3'd1:    begin mode_r = MODE_FALL;    mode_g = MODE_HOLD_HI; mode_b = MODE_HOLD_LO; end
            3'd2:    begin mode_r = MODE_HOLD_LO; mode_g = MODE_HOLD_HI; mode_b = MODE_RISE;    end
            3'd3:    begin mode_r = MODE_HOLD_LO; mode_g = MODE_FALL;    mode_b = MODE_HOLD_HI; end
            3'd4:    begin mode_r = MODE_RISE;    mode_g = MODE_HOLD_LO; mode_b = MODE_HOLD_HI; end
            3'd5:    begin mode_r = MODE_HOLD_HI; mode_g = MODE_HOLD_LO; mode_b = MODE_FALL;    end
            default: begin mode_r = MODE_HOLD_HI; mode_g = MODE_HOLD_LO; mode_b = MODE_HOLD_LO; end
        endcase
    end

    assign bus.phase      = phase_q;
    assign bus.duty_r     = duty_r_q;
    assign bus.duty_g     = duty_g_q;
    assign bus.duty_b     = duty_b_q;
    assign bus.pwm_r      = pwm_r_q;
    assign bus.pwm_g      = pwm_g_q;
    assign bus.pwm_b      = pwm_b_q;
    assign bus.step_tick  = step_tick_q;
    assign bus.phase_done = phase_done_q;
endmodule
